// File: rtl/l2_arbiter.sv
// Two-port arbiter (I-side prefetcher, D-side cache) onto a single L2 port, one outstanding transaction.
// Optional build macro L2_ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests.
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata
);

    // state  | meaning
    // IDLE   | no grant, no L2 command
    // BUSY_I | I-side granted, waiting for l2_resp
    // BUSY_D | D-side granted, waiting for l2_resp
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                read_q,  read_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;

    logic i_pend;
    logic d_pend;
    logic tie_d_wins;
    logic grant_d;
    logic grant_i;

    assign i_pend = i_read | i_write;
    assign d_pend = d_read | d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    logic last_grant_q, last_grant_d;

    // Tie goes to whichever side was not granted last.
    assign tie_d_wins = (last_grant_q == SIDE_I);

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_d) begin
            last_grant_d = SIDE_D;
        end else if (grant_i) begin
            last_grant_d = SIDE_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SIDE_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign tie_d_wins = 1'b1;
`endif

    assign grant_d = (state_q == IDLE) && d_pend && (!i_pend || tie_d_wins);
    assign grant_i = (state_q == IDLE) && i_pend && !grant_d;

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                // A request carrying both read and write is issued as a write.
                if (grant_d) begin
                    state_d = BUSY_D;
                    write_d = d_write;
                    read_d  = d_read & ~d_write;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                    write_d = i_write;
                    read_d  = i_read & ~i_write;
                    addr_d  = i_address;
                    wdata_d = i_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                if (l2_resp) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign l2_read    = read_q;
    assign l2_write   = write_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;

    // Data is broadcast; only the resp pulse tells a requester it is theirs.
    assign i_resp  = (state_q == BUSY_I) && l2_resp;
    assign d_resp  = (state_q == BUSY_D) && l2_resp;
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter; vectors and expected values computed by hand.
module tb_l2_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk;
    logic              rst_n;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_address, d_address;
    logic [LINE_W-1:0] i_wdata, d_wdata;
    logic              i_resp, d_resp;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              l2_read, l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_resp;
    logic [LINE_W-1:0] l2_rdata;

    int n_cmp;
    int n_bad;

    localparam logic [LINE_W-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_WD = {2{64'h0123_4567_89AB_CDEF}};
    localparam logic [LINE_W-1:0] PAT_3C = {16{8'h3C}};

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point is 1ns after the rising edge; checks follow after a further 1ns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cmd(input string tag, input logic rd, input logic wr, input logic [ADDR_W-1:0] a);
        chk({tag, ".l2_read"},  {127'd0, l2_read},  {127'd0, rd});
        chk({tag, ".l2_write"}, {127'd0, l2_write}, {127'd0, wr});
        chk({tag, ".l2_addr"},  {112'd0, l2_address}, {112'd0, a});
    endtask

    task automatic chk_resp(input string tag, input logic ir, input logic dr);
        chk({tag, ".i_resp"}, {127'd0, i_resp}, {127'd0, ir});
        chk({tag, ".d_resp"}, {127'd0, d_resp}, {127'd0, dr});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
        l2_resp = 0; l2_rdata = '0;
        #12;
        chk_cmd("reset", 0, 0, 16'h0000);
        chk("reset.l2_wdata", l2_wdata, '0);
        chk_resp("reset", 0, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // I-read alone, response on the third BUSY cycle
        i_read = 1; i_address = 16'h1230;
        #1 chk_cmd("iread.N", 0, 0, 16'h0000);
        tick(); #1 chk_cmd("iread.b1", 1, 0, 16'h1230); chk_resp("iread.b1", 0, 0);
        tick(); #1 chk_cmd("iread.b2", 1, 0, 16'h1230); chk_resp("iread.b2", 0, 0);
        tick();
        l2_resp = 1; l2_rdata = PAT_A5;
        #1 chk_cmd("iread.b3", 1, 0, 16'h1230);
        chk_resp("iread.b3", 1, 0);
        chk("iread.i_rdata", i_rdata, PAT_A5);
        tick();
        l2_resp = 0; i_read = 0;
        #1 chk_cmd("iread.done", 0, 0, 16'h1230); chk_resp("iread.done", 0, 0);

        // D-write alone, inputs disturbed mid-transaction
        d_write = 1; d_address = 16'h4000; d_wdata = PAT_WD;
        tick();
        d_address = 16'hFFFF; d_wdata = '0;
        #1 chk_cmd("dwr.b1", 0, 1, 16'h4000);
        chk("dwr.b1.wdata", l2_wdata, PAT_WD);
        tick(); #1 chk_cmd("dwr.b2", 0, 1, 16'h4000);
        chk("dwr.b2.wdata", l2_wdata, PAT_WD);
        l2_resp = 1; l2_rdata = PAT_3C;
        #1 chk_resp("dwr.resp", 0, 1);
        chk("dwr.d_rdata", d_rdata, PAT_3C);
        tick();
        l2_resp = 0; d_write = 0;
        #1 chk_cmd("dwr.done", 0, 0, 16'h4000);

        // Two ties in a row, both sides held until their own resp
        for (int t = 0; t < 2; t++) begin
            i_read = 1; i_address = 16'h1000;
            d_read = 1; d_address = 16'h2000;
            tick(); #1 chk_cmd("tie.first", 1, 0, 16'h2000);
            l2_resp = 1;
            #1 chk_resp("tie.first", 0, 1);
            tick();
            l2_resp = 0; d_read = 0;
            #1 chk_cmd("tie.gap", 0, 0, 16'h2000); chk_resp("tie.gap", 0, 0);
            tick(); #1 chk_cmd("tie.second", 1, 0, 16'h1000);
            l2_resp = 1;
            #1 chk_resp("tie.second", 1, 0);
            tick();
            l2_resp = 0; i_read = 0;
            tick();
        end

        // Read and write together resolve to a write
        d_read = 1; d_write = 1; d_address = 16'h3000;
        tick(); #1 chk_cmd("both", 0, 1, 16'h3000);
        l2_resp = 1;
        #1 chk_resp("both", 0, 1);
        tick();
        l2_resp = 0; d_read = 0; d_write = 0;
        tick();

        // Reset in the middle of an I-side transaction
        i_read = 1; i_address = 16'h5550;
        tick(); #1 chk_cmd("rst.busy", 1, 0, 16'h5550);
        rst_n = 0;
        #1 chk_cmd("rst.async", 0, 0, 16'h0000); chk_resp("rst.async", 0, 0);
        i_read = 0;
        tick();
        rst_n = 1;
        tick();
        l2_resp = 1;
        #1 chk_resp("rst.late_resp", 0, 0);
        tick();
        l2_resp = 0;
        #1 chk_cmd("rst.after", 0, 0, 16'h0000);
        d_read = 1; d_address = 16'h6000;
        tick(); #1 chk_cmd("rst.newd", 1, 0, 16'h6000);
        l2_resp = 1;
        #1 chk_resp("rst.newd", 0, 1);
        tick();
        l2_resp = 0; d_read = 0;
        tick();

        // Stray resp in IDLE
        l2_resp = 1;
        #1 chk_resp("stray", 0, 0);
        tick();
        l2_resp = 0;
        #1 chk_cmd("stray.after", 0, 0, 16'h6000); chk_resp("stray.after", 0, 0);
        tick(); #1 chk_cmd("stray.idle", 0, 0, 16'h6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
